// File: rtl/dma_host_cpu_port.sv
// CPU-side slave-port cycle engine: runs register read/write cycles and answers HRQ with HLDA.
// Access is SETUP + STROBE_CYCLES + RECOVER; cmd_ready drops while busy or while HRQ is pending.
// Optional macro HOST_HOLD_TIMEOUT_EN adds a sticky hold_timeout flag for over-long HOLD periods.
`timescale 1ns/1ps
module dma_host_cpu_port #(
  parameter int DATAWIDTH     = 8,
  parameter int STROBE_CYCLES = 2,
  parameter int HLDA_DELAY    = 1,
  parameter int HOLD_TIMEOUT  = 1024
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [3:0]           cmd_addr,
  input  logic [DATAWIDTH-1:0] cmd_wdata,
  output logic                 rsp_valid,
  output logic [DATAWIDTH-1:0] rsp_rdata,
  input  logic                 HRQ,
  output logic                 HLDA,
  output logic                 CS_N,
  inout  wire                  IOR_N,
  inout  wire                  IOW_N,
  inout  wire  [3:0]           A,
  inout  wire  [DATAWIDTH-1:0] DB,
`ifdef HOST_HOLD_TIMEOUT_EN
  output logic                 hold_timeout,
`endif
  output logic                 busy
);

  if (STROBE_CYCLES < 1 || STROBE_CYCLES > 15 || HLDA_DELAY < 0 || HLDA_DELAY > 15 ||
      HOLD_TIMEOUT < 1 || HOLD_TIMEOUT > 65535) begin : g_bad_cfg
    $error("dma_host_cpu_port: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STROBE, S_RECOVER, S_HOLD_WAIT, S_HOLD
  } state_t;

  localparam logic [3:0] LP_STB_LAST = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] LP_HW_LAST  = 4'(HLDA_DELAY - 1);

  state_t               r_state;
  state_t               w_next;
  logic [3:0]           r_cnt;
  logic [3:0]           w_cnt_next;
  logic                 w_accept;
  logic                 r_write;
  logic [3:0]           r_addr;
  logic [DATAWIDTH-1:0] r_wdata;
  logic [DATAWIDTH-1:0] r_rdata;
  logic                 w_access;
  logic                 w_sample;
  logic                 w_rd_strobe;
  logic                 w_wr_strobe;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_write <= cmd_write;
        r_addr  <= cmd_addr;
        r_wdata <= cmd_wdata;
      end
      if (w_sample) r_rdata <= DB;
    end
  end

  // HRQ is only looked at from IDLE, so an access in flight always runs to completion.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_accept   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (HRQ) begin
          w_cnt_next = '0;
          if (HLDA_DELAY == 0) w_next = S_HOLD;
          else                 w_next = S_HOLD_WAIT;
        end else if (cmd_valid) begin
          w_accept = 1'b1;
          w_next   = S_SETUP;
        end
      end
      S_SETUP: begin
        w_cnt_next = '0;
        w_next     = S_STROBE;
      end
      S_STROBE: begin
        if (r_cnt == LP_STB_LAST) w_next = S_RECOVER;
        else                      w_cnt_next = r_cnt + 4'd1;
      end
      S_RECOVER: w_next = S_IDLE;
      S_HOLD_WAIT: begin
        if (!HRQ)                     w_next = S_IDLE;
        else if (r_cnt == LP_HW_LAST) w_next = S_HOLD;
        else                          w_cnt_next = r_cnt + 4'd1;
      end
      S_HOLD: if (!HRQ) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_access    = (r_state == S_SETUP) || (r_state == S_STROBE) || (r_state == S_RECOVER);
  assign w_rd_strobe = (r_state == S_STROBE) && !r_write;
  assign w_wr_strobe = (r_state == S_STROBE) && r_write;
  assign w_sample    = w_rd_strobe && (r_cnt == LP_STB_LAST);

  assign cmd_ready = (r_state == S_IDLE) && !HRQ && RESET_N;
  assign busy      = (r_state != S_IDLE);
  assign HLDA      = (r_state == S_HOLD);
  assign CS_N      = !w_access;
  assign rsp_valid = (r_state == S_RECOVER) && !r_write;
  assign rsp_rdata = r_rdata;

  // Strobes float only in HOLD; they come back high on the IDLE cycle after release.
  assign IOR_N = (r_state == S_HOLD) ? 1'bz : !w_rd_strobe;
  assign IOW_N = (r_state == S_HOLD) ? 1'bz : !w_wr_strobe;
  assign A     = w_access ? r_addr : 4'bz;
  assign DB    = (w_access && r_write) ? r_wdata : {DATAWIDTH{1'bz}};

`ifdef HOST_HOLD_TIMEOUT_EN
  localparam logic [15:0] LP_TO_LAST = 16'(HOLD_TIMEOUT - 1);

  logic [15:0] r_hold_cnt;
  logic        r_hold_to;
  logic        w_to_hit;

  assign w_to_hit = (r_state == S_HOLD) && (r_hold_cnt == LP_TO_LAST);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_hold_cnt <= '0;
      r_hold_to  <= 1'b0;
    end else begin
      if (r_state != S_HOLD)         r_hold_cnt <= '0;
      else if (r_hold_cnt != 16'hFFFF) r_hold_cnt <= r_hold_cnt + 16'd1;
      if (w_to_hit) r_hold_to <= 1'b1;
    end
  end

  assign hold_timeout = r_hold_to || w_to_hit;
`endif

endmodule
